cndm_gt_apb_seq: RTL and testbench

Command-driven APB master that sequences transceiver register access for the 25G MAC/GT block. It converts queued read, write and read-modify-write commands into APB4 transfers on the GT control port. Each APB phase has a bounded timeout, and each command returns exactly one response with status. It sits between the host control register path and the MAC's transceiver APB control interface, replacing a tied-off control port.

---
 rtl/cndm_gt_apb_seq_if.sv | 35 +++
 rtl/cndm_gt_apb_seq.sv | 308 ++++++++++++++++++++++++++++++
 tb/tb_cndm_gt_apb_seq.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cndm_gt_apb_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : cndm_gt_apb_seq_if
// Purpose  : APB4 bus bundle between the GT register sequencer (master) and
//            the MAC transceiver APB control port (slave).
// Signals  : paddr/psel/penable/pwrite/pwdata/pstrb  driven by the master
//            pready/prdata/pslverr                   driven by the slave
// Revision : 1.0  initial release
// ============================================================================
interface cndm_gt_apb_seq_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16,
  parameter int STRB_W = DATA_W / 8
);
  logic [ADDR_W-1:0] paddr;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic [STRB_W-1:0] pstrb;
  logic              pready;
  logic [DATA_W-1:0] prdata;
  logic              pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata, pstrb,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata, pstrb,
    output pready, prdata, pslverr
  );
endinterface
`default_nettype wire

// File: rtl/cndm_gt_apb_seq.sv
`default_nettype none
// ============================================================================
// Module   : cndm_gt_apb_seq
// Purpose  : Command-driven APB4 master that sequences READ, WRITE and
//            read-modify-write accesses to the 25G MAC/GT transceiver
//            registers. Every APB ACCESS phase is bounded by TIMEOUT cycles
//            and every accepted command returns exactly one response.
// Ports    : clk, rst (async, active-low)
//            cmd_*    command handshake (op, addr, wdata, mask)
//            resp_*   response handshake (rdata, status)
//            m_apb    APB4 master port (cndm_gt_apb_seq_if.master)
// Options  : CNDM_GT_APB_SEQ_VERIFY_EN - readback-verify after every
//            successful write phase; a masked mismatch reports status 3.
// Revision : 1.0  initial release
// ============================================================================
module cndm_gt_apb_seq #(
  parameter int ADDR_W  = 18,
  parameter int DATA_W  = 16,
  parameter int STRB_W  = DATA_W / 8,
  parameter int TIMEOUT = 1024
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              cmd_valid,
  output logic                   cmd_ready,
  input  wire logic [1:0]        cmd_op,
  input  wire logic [ADDR_W-1:0] cmd_addr,
  input  wire logic [DATA_W-1:0] cmd_wdata,
  input  wire logic [DATA_W-1:0] cmd_mask,
  output logic                   resp_valid,
  input  wire logic              resp_ready,
  output logic [DATA_W-1:0]      resp_rdata,
  output logic [1:0]             resp_status,
  cndm_gt_apb_seq_if.master      m_apb
);

  localparam int               CNT_W    = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_RMW   = 2'd2;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_SLVERR  = 2'd1;
  localparam logic [1:0] ST_TIMEOUT = 2'd2;
  localparam logic [1:0] ST_BAD     = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_RD_SETUP   = 3'd1,
    S_RD_ACCESS  = 3'd2,
    S_WR_SETUP   = 3'd3,
    S_WR_ACCESS  = 3'd4,
`ifdef CNDM_GT_APB_SEQ_VERIFY_EN
    S_VFY_SETUP  = 3'd5,
    S_VFY_ACCESS = 3'd6,
`endif
    S_RESP       = 3'd7
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        op_q, op_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] mask_q, mask_d;
  logic [DATA_W-1:0] rd_q, rd_d;          // original read value (READ/RMW)
  logic              cmd_ready_q, cmd_ready_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [STRB_W-1:0] pstrb_q, pstrb_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic [1:0]        resp_status_q, resp_status_d;

  // Shared "finish the command" request; every path into RESP goes through it.
  logic              fin;
  logic [DATA_W-1:0] fin_rdata;
  logic [1:0]        fin_status;
  logic [CNT_W-1:0]  cnt_inc;
  logic [DATA_W-1:0] merge;
  logic [DATA_W-1:0] keep_rdata;
`ifdef CNDM_GT_APB_SEQ_VERIFY_EN
  logic [DATA_W-1:0] vfy_mask;
`endif

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    op_d          = op_q;
    wdata_d       = wdata_q;
    mask_d        = mask_q;
    rd_d          = rd_q;
    cmd_ready_d   = cmd_ready_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    resp_valid_d  = resp_valid_q;
    resp_rdata_d  = resp_rdata_q;
    resp_status_d = resp_status_q;
    fin           = 1'b0;
    fin_rdata     = '0;
    fin_status    = ST_OK;
    cnt_inc       = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    merge         = (m_apb.prdata & ~mask_q) | (wdata_q & mask_q);
    keep_rdata    = (op_q == OP_RMW) ? rd_q : '0;
`ifdef CNDM_GT_APB_SEQ_VERIFY_EN
    vfy_mask      = (op_q == OP_WRITE) ? {DATA_W{1'b1}} : mask_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          op_d        = cmd_op;
          wdata_d     = cmd_wdata;
          mask_d      = cmd_mask;
          rd_d        = '0;
          cnt_d       = '0;
          paddr_d     = cmd_addr;
          if (cmd_op == OP_READ || cmd_op == OP_RMW) begin
            state_d  = S_RD_SETUP;
            psel_d   = 1'b1;
            pwrite_d = 1'b0;
            pwdata_d = '0;
            pstrb_d  = '0;
          end else if (cmd_op == OP_WRITE) begin
            state_d  = S_WR_SETUP;
            psel_d   = 1'b1;
            pwrite_d = 1'b1;
            pwdata_d = cmd_wdata;
            pstrb_d  = '1;
          end else begin
            fin        = 1'b1;
            fin_status = ST_BAD;
          end
        end
      end
      S_RD_SETUP: begin
        penable_d = 1'b1;
        state_d   = S_RD_ACCESS;
      end
      S_RD_ACCESS: begin
        // pready is tested first so a completion on the last cycle wins.
        if (m_apb.pready) begin
          rd_d = m_apb.prdata;
          if (m_apb.pslverr) begin
            fin        = 1'b1;
            fin_rdata  = m_apb.prdata;
            fin_status = ST_SLVERR;
          end else if (op_q == OP_RMW) begin
            // Go straight to the write SETUP: penable drops, psel stays.
            state_d   = S_WR_SETUP;
            penable_d = 1'b0;
            pwrite_d  = 1'b1;
            pwdata_d  = merge;
            pstrb_d   = '1;
            cnt_d     = '0;
          end else begin
            fin       = 1'b1;
            fin_rdata = m_apb.prdata;
          end
        end else if (cnt_q == CNT_LAST) begin
          fin        = 1'b1;
          fin_status = ST_TIMEOUT;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_WR_SETUP: begin
        penable_d = 1'b1;
        state_d   = S_WR_ACCESS;
      end
      S_WR_ACCESS: begin
        if (m_apb.pready) begin
          if (m_apb.pslverr) begin
            fin        = 1'b1;
            fin_rdata  = keep_rdata;
            fin_status = ST_SLVERR;
          end else begin
`ifdef CNDM_GT_APB_SEQ_VERIFY_EN
            // pwdata keeps the written value as the readback reference.
            state_d   = S_VFY_SETUP;
            penable_d = 1'b0;
            pwrite_d  = 1'b0;
            pstrb_d   = '0;
            cnt_d     = '0;
`else
            fin       = 1'b1;
            fin_rdata = keep_rdata;
`endif
          end
        end else if (cnt_q == CNT_LAST) begin
          fin        = 1'b1;
          fin_rdata  = keep_rdata;
          fin_status = ST_TIMEOUT;
        end else begin
          cnt_d = cnt_inc;
        end
      end
`ifdef CNDM_GT_APB_SEQ_VERIFY_EN
      S_VFY_SETUP: begin
        penable_d = 1'b1;
        state_d   = S_VFY_ACCESS;
      end
      S_VFY_ACCESS: begin
        if (m_apb.pready) begin
          fin       = 1'b1;
          fin_rdata = keep_rdata;
          if (m_apb.pslverr) begin
            fin_status = ST_SLVERR;
          end else if ((m_apb.prdata & vfy_mask) != (pwdata_q & vfy_mask)) begin
            fin_status = ST_BAD;
          end
        end else if (cnt_q == CNT_LAST) begin
          fin        = 1'b1;
          fin_rdata  = keep_rdata;
          fin_status = ST_TIMEOUT;
        end else begin
          cnt_d = cnt_inc;
        end
      end
`endif
      S_RESP: begin
        if (resp_ready) begin
          state_d       = S_IDLE;
          resp_valid_d  = 1'b0;
          resp_rdata_d  = '0;
          resp_status_d = ST_OK;
          cmd_ready_d   = 1'b1;
        end
      end
      default: begin
        state_d   = S_IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase

    if (fin) begin
      state_d       = S_RESP;
      psel_d        = 1'b0;
      penable_d     = 1'b0;
      resp_valid_d  = 1'b1;
      resp_rdata_d  = fin_rdata;
      resp_status_d = fin_status;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      op_q          <= '0;
      wdata_q       <= '0;
      mask_q        <= '0;
      rd_q          <= '0;
      cmd_ready_q   <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      resp_valid_q  <= 1'b0;
      resp_rdata_q  <= '0;
      resp_status_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      op_q          <= op_d;
      wdata_q       <= wdata_d;
      mask_q        <= mask_d;
      rd_q          <= rd_d;
      cmd_ready_q   <= cmd_ready_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      resp_valid_q  <= resp_valid_d;
      resp_rdata_q  <= resp_rdata_d;
      resp_status_q <= resp_status_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign resp_valid    = resp_valid_q;
  assign resp_rdata    = resp_rdata_q;
  assign resp_status   = resp_status_q;
  assign m_apb.paddr   = paddr_q;
  assign m_apb.psel    = psel_q;
  assign m_apb.penable = penable_q;
  assign m_apb.pwrite  = pwrite_q;
  assign m_apb.pwdata  = pwdata_q;
  assign m_apb.pstrb   = pstrb_q;

endmodule
`default_nettype wire

// File: tb/tb_cndm_gt_apb_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_cndm_gt_apb_seq
// Purpose  : Directed self-checking bench for cndm_gt_apb_seq with a small
//            single-register APB slave (programmable wait states and error).
// Revision : 1.0  initial release
// ============================================================================
module tb_cndm_gt_apb_seq;
  localparam int ADDR_W  = 18;
  localparam int DATA_W  = 16;
  localparam int TIMEOUT = 16;
`ifdef CNDM_GT_APB_SEQ_VERIFY_EN
  localparam int VX = 2;
`else
  localparam int VX = 0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [1:0]        cmd_op = 2'd0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [DATA_W-1:0] cmd_wdata = '0;
  logic [DATA_W-1:0] cmd_mask = '0;
  logic              resp_valid;
  logic              resp_ready = 1'b0;
  logic [DATA_W-1:0] resp_rdata;
  logic [1:0]        resp_status;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cndm_gt_apb_seq_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) apb ();

  cndm_gt_apb_seq #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_mask(cmd_mask),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_status(resp_status),
    .m_apb(apb)
  );

  // Slave model: one register, s_delay wait cycles, optional error / write-ignore.
  logic [15:0] s_reg = 16'h0;
  logic        s_load = 1'b0;
  logic [15:0] s_load_val = 16'h0;
  logic        s_err = 1'b0;
  logic        s_nowrite = 1'b0;
  int          s_delay = 0;
  int          wcnt = 0;
  int          n_rd = 0, n_wr = 0, n_acc = 0, n_psel = 0;
  logic [15:0] last_wr_pwdata = 16'h0;
  logic [1:0]  last_wr_pstrb = 2'b0, last_rd_pstrb = 2'b0;
  logic [17:0] last_wr_paddr = '0, last_rd_paddr = '0;
  wire         done = apb.psel && apb.penable && apb.pready;

  assign apb.pready  = apb.psel && apb.penable && (wcnt >= s_delay);
  assign apb.prdata  = s_reg;
  assign apb.pslverr = s_err && apb.pready;

  always @(posedge clk) begin
    if (apb.psel && apb.penable && !apb.pready) wcnt <= wcnt + 1; else wcnt <= 0;
    if (s_load) s_reg <= s_load_val;
    else if (done && apb.pwrite && !s_err && !s_nowrite) s_reg <= apb.pwdata;
    if (apb.psel && apb.penable) n_acc <= n_acc + 1;
    if (apb.psel) n_psel <= n_psel + 1;
    if (done && apb.pwrite) begin
      n_wr <= n_wr + 1; last_wr_pwdata <= apb.pwdata;
      last_wr_pstrb <= apb.pstrb; last_wr_paddr <= apb.paddr;
    end else if (done) begin
      n_rd <= n_rd + 1; last_rd_pstrb <= apb.pstrb; last_rd_paddr <= apb.paddr;
    end
  end

  task automatic preset(input logic [15:0] v);
    @(negedge clk); s_load_val = v; s_load = 1'b1;
    @(negedge clk); s_load = 1'b0;
  endtask

  // Issues one command; returns latency (cycles after handshake) and response.
  task automatic do_cmd(input logic [1:0] op, input logic [17:0] addr,
                        input logic [15:0] wd, input logic [15:0] mk, input bit accept,
                        output int lat, output logic [15:0] rd, output logic [1:0] st,
                        output logic rdy_after);
    int n; bit got;
    @(negedge clk);
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL cmd_ready_wait: got %b required 1", cmd_ready); end
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_wdata = wd; cmd_mask = mk;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1; got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (resp_valid === 1'b1) begin got = 1'b1; break; end
      @(negedge clk); lat++;
    end
    checks++; if (!got) begin errors++; $display("FAIL resp_wait: resp_valid never rose op=%0d", op); end
    rd = resp_rdata; st = resp_status; rdy_after = 1'b0;
    if (accept && got) begin
      resp_ready = 1'b1; @(negedge clk); resp_ready = 1'b0;
      rdy_after = cmd_ready;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (cmd_ready !== 1'b0 || resp_valid !== 1'b0) begin errors++; $display("FAIL reset_hs: cmd_ready=%b resp_valid=%b required 0 0", cmd_ready, resp_valid); end
    checks++; if (apb.psel !== 1'b0 || apb.penable !== 1'b0) begin errors++; $display("FAIL reset_apb: psel=%b penable=%b required 0 0", apb.psel, apb.penable); end
    checks++; if (resp_rdata !== 16'h0 || resp_status !== 2'd0) begin errors++; $display("FAIL reset_resp: rdata=%h status=%0d required 0 0", resp_rdata, resp_status); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_release: cmd_ready=%b required 1", cmd_ready); end
  endtask

  task automatic test_read();
    int lat, nr, nw; logic [15:0] rd; logic [1:0] st; logic ra;
    s_delay = 0; preset(16'hBEEF); nr = n_rd; nw = n_wr;
    do_cmd(2'd0, 18'h00C2, 16'h0, 16'h0, 1'b1, lat, rd, st, ra);
    checks++; if (lat !== 3) begin errors++; $display("FAIL read_lat: got %0d required 3", lat); end
    checks++; if (rd !== 16'hBEEF) begin errors++; $display("FAIL read_rdata: got %h required beef", rd); end
    checks++; if (st !== 2'd0) begin errors++; $display("FAIL read_status: got %0d required 0", st); end
    checks++; if (n_rd - nr !== 1 || n_wr !== nw) begin errors++; $display("FAIL read_xfers: rd=%0d wr=%0d required 1 0", n_rd - nr, n_wr - nw); end
    checks++; if (last_rd_paddr !== 18'h00C2 || last_rd_pstrb !== 2'b00) begin errors++; $display("FAIL read_bus: paddr=%h pstrb=%b required 00c2 00", last_rd_paddr, last_rd_pstrb); end
    checks++; if (ra !== 1'b1) begin errors++; $display("FAIL read_next_ready: got %b required 1", ra); end
  endtask

  task automatic test_rmw();
    int lat, nr, nw; logic [15:0] rd; logic [1:0] st; logic ra;
    preset(16'hFF00); nr = n_rd; nw = n_wr;
    do_cmd(2'd2, 18'h1000, 16'h00AA, 16'h00FF, 1'b1, lat, rd, st, ra);
    checks++; if (lat !== 5 + VX) begin errors++; $display("FAIL rmw_lat: got %0d required %0d", lat, 5 + VX); end
    checks++; if (rd !== 16'hFF00 || st !== 2'd0) begin errors++; $display("FAIL rmw_resp: rdata=%h status=%0d required ff00 0", rd, st); end
    checks++; if (last_wr_pwdata !== 16'hFFAA || last_wr_pstrb !== 2'b11 || last_wr_paddr !== 18'h1000) begin errors++; $display("FAIL rmw_write: pwdata=%h pstrb=%b paddr=%h required ffaa 11 1000", last_wr_pwdata, last_wr_pstrb, last_wr_paddr); end
    checks++; if (n_wr - nw !== 1 || n_rd - nr !== 1 + VX / 2) begin errors++; $display("FAIL rmw_xfers: wr=%0d rd=%0d required 1 %0d", n_wr - nw, n_rd - nr, 1 + VX / 2); end
    checks++; if (s_reg !== 16'hFFAA) begin errors++; $display("FAIL rmw_reg: got %h required ffaa", s_reg); end
  endtask

  task automatic test_write();
    int lat; logic [15:0] rd; logic [1:0] st; logic ra;
    preset(16'h0000);
    do_cmd(2'd1, 18'h0010, 16'h1234, 16'h0, 1'b1, lat, rd, st, ra);
    checks++; if (lat !== 3 + VX || rd !== 16'h0 || st !== 2'd0) begin errors++; $display("FAIL write_resp: lat=%0d rdata=%h status=%0d required %0d 0 0", lat, rd, st, 3 + VX); end
    checks++; if (s_reg !== 16'h1234 || last_wr_pstrb !== 2'b11) begin errors++; $display("FAIL write_bus: reg=%h pstrb=%b required 1234 11", s_reg, last_wr_pstrb); end
  endtask

  task automatic test_timeout();
    int lat, na, nw; logic [15:0] rd; logic [1:0] st; logic ra;
    s_delay = 1000; na = n_acc; nw = n_wr;
    do_cmd(2'd1, 18'h0020, 16'h5555, 16'h0, 1'b1, lat, rd, st, ra);
    checks++; if (st !== 2'd2 || rd !== 16'h0) begin errors++; $display("FAIL timeout_resp: status=%0d rdata=%h required 2 0", st, rd); end
    checks++; if (n_acc - na !== TIMEOUT) begin errors++; $display("FAIL timeout_access_cycles: got %0d required %0d", n_acc - na, TIMEOUT); end
    checks++; if (lat !== TIMEOUT + 2 || n_wr !== nw) begin errors++; $display("FAIL timeout_lat: lat=%0d writes=%0d required %0d 0", lat, n_wr - nw, TIMEOUT + 2); end
    // pready on the final allowed cycle still completes the transfer.
    s_delay = TIMEOUT - 1; preset(16'h0000);
    do_cmd(2'd1, 18'h0024, 16'h6789, 16'h0, 1'b1, lat, rd, st, ra);
    checks++; if (st !== 2'd0 || s_reg !== 16'h6789) begin errors++; $display("FAIL timeout_pready_wins: status=%0d reg=%h required 0 6789", st, s_reg); end
    s_delay = 0; preset(16'h0A0A);
    do_cmd(2'd0, 18'h0030, 16'h0, 16'h0, 1'b1, lat, rd, st, ra);
    checks++; if (st !== 2'd0 || rd !== 16'h0A0A) begin errors++; $display("FAIL timeout_recover: status=%0d rdata=%h required 0 0a0a", st, rd); end
  endtask

  task automatic test_slverr();
    int lat, nr, nw; logic [15:0] rd; logic [1:0] st; logic ra;
    preset(16'h5A5A); s_err = 1'b1; nr = n_rd; nw = n_wr;
    do_cmd(2'd2, 18'h0040, 16'hFFFF, 16'h00FF, 1'b1, lat, rd, st, ra);
    checks++; if (st !== 2'd1 || rd !== 16'h5A5A || lat !== 3) begin errors++; $display("FAIL slverr_rmw: status=%0d rdata=%h lat=%0d required 1 5a5a 3", st, rd, lat); end
    checks++; if (n_wr !== nw || n_rd - nr !== 1) begin errors++; $display("FAIL slverr_xfers: wr=%0d rd=%0d required 0 1", n_wr - nw, n_rd - nr); end
    do_cmd(2'd1, 18'h0044, 16'h1111, 16'h0, 1'b1, lat, rd, st, ra);
    checks++; if (st !== 2'd1 || rd !== 16'h0) begin errors++; $display("FAIL slverr_write: status=%0d rdata=%h required 1 0", st, rd); end
    s_err = 1'b0;
  endtask

  task automatic test_badop();
    int lat, np, nr; logic [15:0] rd; logic [1:0] st; logic ra;
    np = n_psel; nr = n_rd;
    do_cmd(2'd3, 18'h0050, 16'h1234, 16'hFFFF, 1'b0, lat, rd, st, ra);
    checks++; if (st !== 2'd3 || rd !== 16'h0 || lat !== 1) begin errors++; $display("FAIL badop_resp: status=%0d rdata=%h lat=%0d required 3 0 1", st, rd, lat); end
    cmd_valid = 1'b1; cmd_op = 2'd0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if (resp_valid !== 1'b1 || resp_status !== 2'd3 || resp_rdata !== 16'h0 || cmd_ready !== 1'b0) begin errors++; $display("FAIL badop_hold: cyc=%0d valid=%b status=%0d rdata=%h cmd_ready=%b required 1 3 0 0", i, resp_valid, resp_status, resp_rdata, cmd_ready); end
    end
    cmd_valid = 1'b0; resp_ready = 1'b1;
    @(negedge clk); resp_ready = 1'b0;
    checks++; if (cmd_ready !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL badop_release: cmd_ready=%b resp_valid=%b required 1 0", cmd_ready, resp_valid); end
    checks++; if (n_psel !== np || n_rd !== nr) begin errors++; $display("FAIL badop_apb: psel_cycles=%0d reads=%0d required 0 0", n_psel - np, n_rd - nr); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [15:0] rd; logic [1:0] st; logic ra;
    preset(16'h1357); resp_ready = 1'b1;
    do_cmd(2'd0, 18'h0060, 16'h0, 16'h0, 1'b1, lat, rd, st, ra);
    checks++; if (lat !== 3 || rd !== 16'h1357 || ra !== 1'b1) begin errors++; $display("FAIL b2b_first: lat=%0d rdata=%h next_ready=%b required 3 1357 1", lat, rd, ra); end
    resp_ready = 1'b1;
    do_cmd(2'd0, 18'h0062, 16'h0, 16'h0, 1'b1, lat, rd, st, ra);
    checks++; if (lat !== 3 || rd !== 16'h1357 || st !== 2'd0 || resp_valid !== 1'b0) begin errors++; $display("FAIL b2b_second: lat=%0d rdata=%h status=%0d valid=%b required 3 1357 0 0", lat, rd, st, resp_valid); end
  endtask

  task automatic test_reset_mid();
    int n, lat; logic [15:0] rd; logic [1:0] st; logic ra;
    s_delay = 1000;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'd2; cmd_addr = 18'h0070; cmd_wdata = 16'h00FF; cmd_mask = 16'h00FF;
    @(posedge clk); @(negedge clk); cmd_valid = 1'b0;
    n = 0;
    while (!(apb.psel && apb.penable) && n < 10) begin @(negedge clk); n++; end
    checks++; if (apb.penable !== 1'b1) begin errors++; $display("FAIL rstmid_access: penable=%b required 1", apb.penable); end
    #2 rst = 1'b0;
    #1;
    checks++; if (apb.psel !== 1'b0 || apb.penable !== 1'b0 || resp_valid !== 1'b0 || cmd_ready !== 1'b0) begin errors++; $display("FAIL rstmid_async: psel=%b penable=%b valid=%b cmd_ready=%b required 0 0 0 0", apb.psel, apb.penable, resp_valid, cmd_ready); end
    repeat (3) @(negedge clk);
    rst = 1'b1; s_delay = 0;
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_release: cmd_ready=%b valid=%b required 1 0", cmd_ready, resp_valid); end
    preset(16'h0C0C);
    do_cmd(2'd0, 18'h0074, 16'h0, 16'h0, 1'b1, lat, rd, st, ra);
    checks++; if (lat !== 3 || rd !== 16'h0C0C || st !== 2'd0) begin errors++; $display("FAIL rstmid_read: lat=%0d rdata=%h status=%0d required 3 0c0c 0", lat, rd, st); end
  endtask

`ifdef CNDM_GT_APB_SEQ_VERIFY_EN
  task automatic test_verify();
    int lat; logic [15:0] rd; logic [1:0] st; logic ra;
    s_nowrite = 1'b1; preset(16'h0000);
    do_cmd(2'd1, 18'h0080, 16'hABCD, 16'h0, 1'b1, lat, rd, st, ra);
    checks++; if (st !== 2'd3 || rd !== 16'h0 || lat !== 5) begin errors++; $display("FAIL verify_write: status=%0d rdata=%h lat=%0d required 3 0 5", st, rd, lat); end
    preset(16'hF0F0);
    do_cmd(2'd2, 18'h0084, 16'h000F, 16'h000F, 1'b1, lat, rd, st, ra);
    checks++; if (st !== 2'd3 || rd !== 16'hF0F0) begin errors++; $display("FAIL verify_rmw: status=%0d rdata=%h required 3 f0f0", st, rd); end
    s_nowrite = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_read();
    test_rmw();
    test_write();
    test_timeout();
    test_slverr();
    test_badop();
    test_back_to_back();
    test_reset_mid();
`ifdef CNDM_GT_APB_SEQ_VERIFY_EN
    test_verify();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire
